// File: rtl/operand_collect.sv
// operand_collect
//   Decode-to-execute operand collection stage. Holds NUM_SRC source operands
//   plus one destination (rd) descriptor. Slots flagged as pending wait for a
//   matching write on any of NUM_WB writeback/forwarding ports. While any
//   slot is pending, the stage requests a stall.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   pause          downstream hold; when 0 the stage loads from decode
//   flush          discard the held instruction
//   de_rs          source values from register read, slot i at [i*XLEN +: XLEN]
//   de_wait        per-slot pending flags, bit NUM_SRC is rd
//   de_tag/de_idx  per-slot bank tag and register index
//   wb_en/wb_add/wb_data  writeback ports, port 0 has highest priority
//   oc_rs          resolved source operands, forwarded in the same cycle
//   oc_rd_tag/oc_rd_idx   held rd descriptor
//   oc_ready       per-slot resolved flag, including this cycle's forwarding
//   oc_pause       stall request, combinational
//   oc_stall_cnt   saturating count of consecutive stall cycles
module operand_collect #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_WB  = 5,
  parameter int TAG_W   = 2,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pause,
  input  logic                                flush,
  input  logic [NUM_SRC*XLEN-1:0]             de_rs,
  input  logic [NUM_SRC:0]                    de_wait,
  input  logic [(NUM_SRC+1)*TAG_W-1:0]        de_tag,
  input  logic [(NUM_SRC+1)*IDX_W-1:0]        de_idx,
  input  logic [NUM_WB-1:0]                   wb_en,
  input  logic [NUM_WB*(TAG_W+IDX_W)-1:0]     wb_add,
  input  logic [NUM_WB*XLEN-1:0]              wb_data,
  output logic [NUM_SRC*XLEN-1:0]             oc_rs,
  output logic [TAG_W-1:0]                    oc_rd_tag,
  output logic [IDX_W-1:0]                    oc_rd_idx,
  output logic [NUM_SRC:0]                    oc_ready,
  output logic                                oc_pause,
  output logic [CNT_W-1:0]                    oc_stall_cnt
);

  localparam int NS = NUM_SRC + 1;
  localparam int AW = TAG_W + IDX_W;

  logic [XLEN-1:0]   data_q [NUM_SRC];
  logic [TAG_W-1:0]  tag_q  [NS];
  logic [IDX_W-1:0]  idx_q  [NS];
  logic [NS-1:0]     wait_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [AW-1:0]     slot_addr [NS];
  logic [NUM_WB-1:0] hit       [NS];
  logic [NS-1:0]     any_hit;
  logic [XLEN-1:0]   fwd       [NUM_SRC];

  // Bank tags are 1-based (tag 0 means "no register"), so the physical
  // address uses tag-1 wrapped to TAG_W bits.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      slot_addr[i] = {TAG_W'(tag_q[i] - TAG_W'(1)), idx_q[i]};
      for (int p = 0; p < NUM_WB; p++) begin
        hit[i][p] = wait_q[i] & wb_en[p] & (wb_add[p*AW +: AW] == slot_addr[i]);
      end
      any_hit[i] = |hit[i];
    end
  end

  // Scan from the highest port down so the lowest-index hitting port wins.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd[i] = data_q[i];
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (hit[i][p]) begin
          fwd[i] = wb_data[p*XLEN +: XLEN];
        end
      end
      oc_rs[i*XLEN +: XLEN] = fwd[i];
    end
  end

  assign oc_ready     = ~wait_q | any_hit;
  assign oc_pause     = ~&oc_ready;
  assign oc_rd_tag    = tag_q[NUM_SRC];
  assign oc_rd_idx    = idx_q[NUM_SRC];
  assign oc_stall_cnt = cnt_q;

  // Slot state: reset > flush > load > resolve. A write coincident with a
  // load is not captured; decode sees it through its own bypass.
  // The stall counter holds on a flush edge and clears on the following
  // edge once the stall has dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) data_q[i] <= '0;
      for (int i = 0; i < NS; i++) begin
        tag_q[i] <= '0;
        idx_q[i] <= '0;
      end
      wait_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < NUM_SRC; i++) data_q[i] <= '0;
        for (int i = 0; i < NS; i++) begin
          tag_q[i] <= '0;
          idx_q[i] <= '0;
        end
        wait_q <= '0;
      end else if (!pause) begin
        for (int i = 0; i < NUM_SRC; i++) data_q[i] <= de_rs[i*XLEN +: XLEN];
        for (int i = 0; i < NS; i++) begin
          tag_q[i]  <= de_tag[i*TAG_W +: TAG_W];
          idx_q[i]  <= de_idx[i*IDX_W +: IDX_W];
          wait_q[i] <= de_wait[i] & (de_tag[i*TAG_W +: TAG_W] != '0);
        end
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (any_hit[i]) wait_q[i] <= 1'b0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
          if (any_hit[i]) data_q[i] <= fwd[i];
        end
      end

      if (!flush) begin
        if (oc_pause) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
        end else begin
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_collect.sv
// tb_operand_collect
//   Directed plus randomized bench for operand_collect. Two instances share
//   all inputs: one with the default 8-bit stall counter and one with a 3-bit
//   counter so saturation can be seen quickly. A slot-level reference model
//   predicts every output.
module tb_operand_collect;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 2;
  localparam int NUM_WB  = 5;
  localparam int TAG_W   = 2;
  localparam int IDX_W   = 5;
  localparam int NS      = NUM_SRC + 1;
  localparam int AW      = TAG_W + IDX_W;

  logic                      clk = 1'b0;
  logic                      reset, pause, flush;
  logic [NUM_SRC*XLEN-1:0]   de_rs;
  logic [NS-1:0]             de_wait;
  logic [NS*TAG_W-1:0]       de_tag;
  logic [NS*IDX_W-1:0]       de_idx;
  logic [NUM_WB-1:0]         wb_en;
  logic [NUM_WB*AW-1:0]      wb_add;
  logic [NUM_WB*XLEN-1:0]    wb_data;

  logic [NUM_SRC*XLEN-1:0]   oc_rs, oc_rs3;
  logic [TAG_W-1:0]          oc_rd_tag, oc_rd_tag3;
  logic [IDX_W-1:0]          oc_rd_idx, oc_rd_idx3;
  logic [NS-1:0]             oc_ready, oc_ready3;
  logic                      oc_pause, oc_pause3;
  logic [7:0]                oc_stall_cnt;
  logic [2:0]                oc_stall_cnt3;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one entry per slot
  logic [XLEN-1:0] m_data [NUM_SRC];
  int              m_tag  [NS];
  int              m_idx  [NS];
  bit              m_wait [NS];
  int              m_cnt8, m_cnt3;

  // Predicted combinational outputs
  logic [NUM_SRC*XLEN-1:0] e_rs;
  logic [NS-1:0]           e_ready;
  bit                      e_pause;
  bit                      e_hit [NS];
  logic [XLEN-1:0]         e_fwd [NS];

  operand_collect dut (
    .clk(clk), .reset(reset), .pause(pause), .flush(flush),
    .de_rs(de_rs), .de_wait(de_wait), .de_tag(de_tag), .de_idx(de_idx),
    .wb_en(wb_en), .wb_add(wb_add), .wb_data(wb_data),
    .oc_rs(oc_rs), .oc_rd_tag(oc_rd_tag), .oc_rd_idx(oc_rd_idx),
    .oc_ready(oc_ready), .oc_pause(oc_pause), .oc_stall_cnt(oc_stall_cnt)
  );

  operand_collect #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .pause(pause), .flush(flush),
    .de_rs(de_rs), .de_wait(de_wait), .de_tag(de_tag), .de_idx(de_idx),
    .wb_en(wb_en), .wb_add(wb_add), .wb_data(wb_data),
    .oc_rs(oc_rs3), .oc_rd_tag(oc_rd_tag3), .oc_rd_idx(oc_rd_idx3),
    .oc_ready(oc_ready3), .oc_pause(oc_pause3), .oc_stall_cnt(oc_stall_cnt3)
  );

  always #5 clk = ~clk;

  // Slot address = (tag-1 mod 4)*32 + idx; first enabled port with a
  // matching address supplies the value.
  task automatic predict();
    for (int i = 0; i < NS; i++) begin
      int addr;
      addr = ((m_tag[i] + 3) % 4) * 32 + m_idx[i];
      e_hit[i] = 1'b0;
      e_fwd[i] = '0;
      for (int p = 0; p < NUM_WB; p++) begin
        if (!e_hit[i] && m_wait[i] && wb_en[p] && int'(wb_add[p*AW +: AW]) == addr) begin
          e_hit[i] = 1'b1;
          e_fwd[i] = wb_data[p*XLEN +: XLEN];
        end
      end
      e_ready[i] = !m_wait[i] || e_hit[i];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      e_rs[i*XLEN +: XLEN] = e_hit[i] ? e_fwd[i] : m_data[i];
    end
    e_pause = (e_ready != {NS{1'b1}});
  endtask

  task automatic clearModel();
    for (int i = 0; i < NUM_SRC; i++) m_data[i] = '0;
    for (int i = 0; i < NS; i++) begin
      m_tag[i] = 0;
      m_idx[i] = 0;
      m_wait[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic modelEdge();
    predict();
    if (reset) begin
      clearModel();
      m_cnt8 = 0;
      m_cnt3 = 0;
    end else begin
      if (flush) begin
        clearModel();
      end else if (!pause) begin
        for (int i = 0; i < NS; i++) begin
          m_tag[i]  = int'(de_tag[i*TAG_W +: TAG_W]);
          m_idx[i]  = int'(de_idx[i*IDX_W +: IDX_W]);
          m_wait[i] = de_wait[i] && (m_tag[i] != 0);
        end
        for (int i = 0; i < NUM_SRC; i++) m_data[i] = de_rs[i*XLEN +: XLEN];
      end else begin
        for (int i = 0; i < NS; i++) begin
          if (e_hit[i]) begin
            m_wait[i] = 1'b0;
            if (i < NUM_SRC) m_data[i] = e_fwd[i];
          end
        end
      end
      if (!flush) begin
        if (e_pause) begin
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt3 = (m_cnt3 < 7) ? m_cnt3 + 1 : 7;
        end else begin
          m_cnt8 = 0;
          m_cnt3 = 0;
        end
      end
    end
  endtask

  task automatic expectVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    predict();
    expectVal({tag, ".oc_rs"},        64'(oc_rs),         64'(e_rs));
    expectVal({tag, ".oc_ready"},     64'(oc_ready),      64'(e_ready));
    expectVal({tag, ".oc_pause"},     64'(oc_pause),      64'(e_pause));
    expectVal({tag, ".oc_rd_tag"},    64'(oc_rd_tag),     64'(m_tag[NUM_SRC]));
    expectVal({tag, ".oc_rd_idx"},    64'(oc_rd_idx),     64'(m_idx[NUM_SRC]));
    expectVal({tag, ".oc_stall_cnt"}, 64'(oc_stall_cnt),  64'(m_cnt8));
    expectVal({tag, ".cnt3"},         64'(oc_stall_cnt3), 64'(m_cnt3));
    expectVal({tag, ".oc_rs3"},       64'(oc_rs3),        64'(e_rs));
  endtask

  // Check the current cycle, then clock once and advance the model
  task automatic applyStimulus(input string tag);
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic clearInputs();
    pause = 1'b1; flush = 1'b0;
    de_rs = '0; de_wait = '0; de_tag = '0; de_idx = '0;
    wb_en = '0; wb_add = '0; wb_data = '0;
  endtask

  task automatic setSlot(input int i, input int tag, input int idx, input bit w);
    de_tag[i*TAG_W +: TAG_W] = TAG_W'(tag);
    de_idx[i*IDX_W +: IDX_W] = IDX_W'(idx);
    de_wait[i] = w;
  endtask

  task automatic setPort(input int p, input int addr, input logic [XLEN-1:0] data);
    wb_en[p] = 1'b1;
    wb_add[p*AW +: AW] = AW'(addr);
    wb_data[p*XLEN +: XLEN] = data;
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    clearModel();
    m_cnt8 = 0;
    m_cnt3 = 0;
    repeat (2) begin
      @(posedge clk);
      modelEdge();
    end
    #1 reset = 1'b0;

    #1;
    expectVal("reset.ready", 64'(oc_ready), 64'h7);
    expectVal("reset.pause", 64'(oc_pause), 64'h0);
    expectVal("reset.rs",    64'(oc_rs),    64'h0);

    // Plain load with nothing pending
    pause = 1'b0;
    de_rs = {32'h2, 32'h1};
    applyStimulus("load_plain");
    clearInputs();
    expectVal("load_plain.rs", 64'(oc_rs), {32'h2, 32'h1});
    expectVal("load_plain.ready", 64'(oc_ready), 64'h7);

    // Slot0 waits on 7'h05, resolved by port 3 after three idle cycles
    pause = 1'b0;
    setSlot(0, 1, 5, 1'b1);
    applyStimulus("load_wait0");
    clearInputs();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus("idle_wait0");
      expectVal("idle_wait0.cnt", 64'(oc_stall_cnt), 64'(k));
    end
    setPort(3, 7'h05, 32'hDEAD);
    #1;
    expectVal("hit_wait0.rs0", 64'(oc_rs[31:0]), 64'hDEAD);
    expectVal("hit_wait0.pause", 64'(oc_pause), 64'h0);
    applyStimulus("hit_wait0");
    clearInputs();
    #1;
    expectVal("held_wait0.rs0", 64'(oc_rs[31:0]), 64'hDEAD);
    expectVal("held_wait0.cnt", 64'(oc_stall_cnt), 64'h0);

    // Both sources wait on 7'h25; ports 1 and 4 hit, port 1 wins
    pause = 1'b0;
    setSlot(0, 2, 5, 1'b1);
    setSlot(1, 2, 5, 1'b1);
    applyStimulus("load_dual");
    clearInputs();
    setPort(1, 7'h25, 32'h11);
    setPort(4, 7'h25, 32'h44);
    #1;
    expectVal("dual.rs", 64'(oc_rs), {32'h11, 32'h11});
    applyStimulus("dual");
    clearInputs();
    #1;
    expectVal("dual_after.ready", 64'(oc_ready), 64'h7);
    expectVal("dual_after.rs", 64'(oc_rs), {32'h11, 32'h11});

    // rd waits on 7'h23
    pause = 1'b0;
    setSlot(2, 2, 3, 1'b1);
    applyStimulus("load_rd");
    clearInputs();
    repeat (2) applyStimulus("idle_rd");
    expectVal("idle_rd.pause", 64'(oc_pause), 64'h1);
    setPort(0, 7'h23, 32'h5555);
    #1;
    expectVal("hit_rd.pause", 64'(oc_pause), 64'h0);
    expectVal("hit_rd.tag", 64'(oc_rd_tag), 64'h2);
    expectVal("hit_rd.idx", 64'(oc_rd_idx), 64'h3);
    applyStimulus("hit_rd");
    clearInputs();

    // Tag 0 suppresses the wait flag
    pause = 1'b0;
    setSlot(1, 0, 7, 1'b1);
    applyStimulus("load_tag0");
    clearInputs();
    expectVal("tag0.ready", 64'(oc_ready), 64'h7);
    expectVal("tag0.pause", 64'(oc_pause), 64'h0);

    // Flush during a stall
    pause = 1'b0;
    setSlot(0, 1, 9, 1'b1);
    de_rs = {32'hAAAA, 32'hBBBB};
    applyStimulus("load_flush");
    clearInputs();
    repeat (2) applyStimulus("stall_flush");
    flush = 1'b1;
    pause = 1'b0;
    de_rs = {32'h1234, 32'h5678};
    setSlot(0, 1, 9, 1'b1);
    applyStimulus("flush");
    clearInputs();
    expectVal("flush.pause", 64'(oc_pause), 64'h0);
    expectVal("flush.rs", 64'(oc_rs), 64'h0);
    expectVal("flush.cnt_held", 64'(oc_stall_cnt), 64'h2);
    applyStimulus("after_flush");
    expectVal("after_flush.cnt", 64'(oc_stall_cnt), 64'h0);

    // Long stall: the 3-bit counter saturates at 7
    pause = 1'b0;
    setSlot(0, 3, 17, 1'b1);
    applyStimulus("load_sat");
    clearInputs();
    repeat (10) applyStimulus("stall_sat");
    expectVal("sat.cnt3", 64'(oc_stall_cnt3), 64'h7);
    expectVal("sat.cnt8", 64'(oc_stall_cnt), 64'd10);

    // Randomized traffic over a small address space so hits are frequent
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 5);
      pause = ($urandom_range(0, 99) < 70);
      de_rs = {$urandom, $urandom};
      de_wait = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        de_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 3));
        de_idx[i*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 3));
      end
      wb_en = NUM_WB'($urandom) & NUM_WB'($urandom);
      for (int p = 0; p < NUM_WB; p++) begin
        wb_add[p*AW +: AW] = AW'($urandom_range(0, 3) * 32 + $urandom_range(0, 3));
        wb_data[p*XLEN +: XLEN] = $urandom;
      end
      applyStimulus("random");
    end
    reset = 1'b0;
    clearInputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
